// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: widths, FSM states and
// the request bundle that is steered onto the single memory port.
package dmem_arbiter_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        S_CPU  = 2'd0,
        S_HOST = 2'd1,
        S_ACK  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
    } mem_req_t;

endpackage

// File: rtl/dmem_port_mux.sv
// 2:1 steering of {addr, wdata, we} onto the memory port. Pure combinational;
// the grant decision lives in dmem_arbiter.
module dmem_port_mux
    import dmem_arbiter_pkg::*;
(
    input  mem_req_t cpu_i,
    input  mem_req_t host_i,
    input  logic     sel_host_i,
    output mem_req_t mem_o
);

    assign mem_o = sel_host_i ? host_i : cpu_i;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage and the host/debug port.
// CPU has priority; a saturating wait counter forces a host slot after
// MAX_WAIT lost cycles. A host access costs the pipeline one stall cycle.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_dataout,
    input  logic [DATA_W-1:0] d_datain,
    output logic              d_we
);

    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [DATA_W-1:0] host_rdata_q;
    logic              host_sel;
    mem_req_t          cpu_side, host_side, mem_sel;

    assign cpu_side  = '{addr: cpu_addr,  wdata: cpu_wdata,  we: cpu_req & cpu_we};
    assign host_side = '{addr: host_addr, wdata: host_wdata, we: host_we};

    dmem_port_mux u_mux (
        .cpu_i      (cpu_side),
        .host_i     (host_side),
        .sel_host_i (host_sel),
        .mem_o      (mem_sel)
    );

    // Reset gates the write strobe directly so an in-flight host write is
    // dropped the moment reset asserts, not at the next edge.
    assign d_addr     = mem_sel.addr;
    assign d_dataout  = mem_sel.wdata;
    assign d_we       = mem_sel.we & reset;
    assign cpu_rdata  = d_datain;
    assign host_rdata = host_rdata_q;

    // Next-state, wait counter and per-state port control.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        host_sel  = 1'b0;
        cpu_stall = 1'b0;
        host_ack  = 1'b0;
        case (state_q)
            S_CPU: begin
                if (host_req) begin
                    if (!cpu_req || wait_q == WAIT_MAX) begin
                        state_d = S_HOST;
                    end else if (wait_q != WAIT_MAX) begin
                        wait_d = wait_q + CNT_W'(1);
                    end
                end else begin
                    wait_d = '0;
                end
            end
            S_HOST: begin
                host_sel  = 1'b1;
                cpu_stall = cpu_req;
                wait_d    = '0;
                state_d   = S_ACK;
            end
            S_ACK: begin
                // No grant here: a request still high next cycle is a new one.
                host_ack = 1'b1;
                state_d  = S_CPU;
            end
            default: begin
                state_d = S_CPU;
                wait_d  = '0;
            end
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_CPU;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Capture host read data at the end of the host slot; writes leave it alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            host_rdata_q <= '0;
        end else if (state_q == S_HOST && !host_we) begin
            host_rdata_q <= d_datain;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural data memory, directed stimulus, and a
// scoreboard monitor that checks host acks and unstalled CPU reads.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        host_req, host_we;
    logic [7:0]  host_addr;
    logic [15:0] host_wdata, host_rdata;
    logic        host_ack;
    logic [7:0]  d_addr;
    logic [15:0] d_dataout, d_datain;
    logic        d_we;

    typedef struct {
        logic [15:0] rdata;
        int          cyc;
    } hexp_t;

    hexp_t       host_exp[$];
    logic [15:0] cpu_exp[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [15:0] mem [256];

    dmem_arbiter #(.MAX_WAIT(4), .CNT_W(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack),
        .d_addr     (d_addr),
        .d_dataout  (d_dataout),
        .d_datain   (d_datain),
        .d_we       (d_we)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Memory: synchronous write, asynchronous read.
    always @(posedge clock) if (d_we) mem[d_addr] <= d_dataout;
    assign d_datain = mem[d_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    // Scoreboard monitor.
    always @(negedge clock) begin
        hexp_t       e;
        logic [15:0] c;
        if (host_ack) begin
            if (host_exp.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_host_ack actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                e = host_exp.pop_front();
                check("host_rdata", {16'h0, host_rdata}, {16'h0, e.rdata});
                check("host_ack_cycle", cyc, e.cyc);
            end
        end
        if (reset && cpu_req && !cpu_we && !cpu_stall) begin
            if (cpu_exp.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_cpu_read actual=%0h expected=none (cycle %0d)", cpu_rdata, cyc);
            end else begin
                c = cpu_exp.pop_front();
                check("cpu_rdata", {16'h0, cpu_rdata}, {16'h0, c});
            end
        end
    end

    // Hard time limit.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h33; cpu_wdata = 16'hDEAD;
        host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 16'h0000;

        // Reset values
        smp();
        check("rst_host_ack",   {31'h0, host_ack},  32'h0);
        check("rst_cpu_stall",  {31'h0, cpu_stall}, 32'h0);
        check("rst_host_rdata", {16'h0, host_rdata}, 32'h0);
        check("rst_d_we",       {31'h0, d_we},      32'h0);
        check("rst_d_addr",     {24'h0, d_addr},    32'h33);
        #2 reset = 1'b1;
        cpu_req = 1'b0;
        nxt();

        // 1: CPU only store then load
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 16'hBEEF;
        smp();
        check("t1_d_we",      {31'h0, d_we},      32'h1);
        check("t1_d_addr",    {24'h0, d_addr},    32'h10);
        check("t1_d_dataout", {16'h0, d_dataout}, 32'hBEEF);
        check("t1_cpu_stall", {31'h0, cpu_stall}, 32'h0);
        nxt();
        cpu_we = 1'b0;
        cpu_exp.push_back(16'hBEEF);
        smp();
        nxt();

        // 2: host only read
        cpu_req = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        host_exp.push_back('{16'hBEEF, cyc + 2});
        smp();
        check("t2_stall_req", {31'h0, cpu_stall}, 32'h0);
        nxt();
        smp();
        check("t2_host_d_addr", {24'h0, d_addr}, 32'h10);
        nxt();
        host_req = 1'b0;
        smp();
        nxt();

        // 3: starvation bound under continuous CPU stores
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 16'h1111;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        host_exp.push_back('{16'hBEEF, cyc + 6});
        for (int i = 0; i < 7; i++) begin
            if (i == 6) host_req = 1'b0;
            smp();
            check($sformatf("t3_stall_%0d", i), {31'h0, cpu_stall}, (i == 5) ? 32'h1 : 32'h0);
            if (i == 5) begin
                check("t3_no_cpu_write", {31'h0, d_we},   32'h0);
                check("t3_host_addr",    {24'h0, d_addr}, 32'h10);
            end
            nxt();
        end

        // 4: conflict retry, host write lands first, CPU store retried after
        cpu_addr = 8'h21; cpu_wdata = 16'hAAAA;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 16'h5555;
        host_exp.push_back('{16'hBEEF, cyc + 6});
        for (int i = 0; i < 7; i++) begin
            if (i == 4) begin cpu_addr = 8'h20; cpu_wdata = 16'h1234; end
            if (i == 6) host_req = 1'b0;
            smp();
            if (i == 5) begin
                check("t4_host_we",    {31'h0, d_we},      32'h1);
                check("t4_host_wdata", {16'h0, d_dataout}, 32'h5555);
                check("t4_stall",      {31'h0, cpu_stall}, 32'h1);
            end
            if (i == 6) check("t4_host_first", {16'h0, mem[8'h20]}, 32'h5555);
            nxt();
        end
        cpu_we = 1'b0; cpu_addr = 8'h20;
        cpu_exp.push_back(16'h1234);
        smp();
        nxt();

        // 5: withdrawal clears the wait counter
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) host_req = 1'b0;
            cpu_exp.push_back(16'hBEEF);
            smp();
            check($sformatf("t5_wd_stall_%0d", i), {31'h0, cpu_stall}, 32'h0);
            nxt();
        end
        host_req = 1'b1;
        host_exp.push_back('{16'h1234, cyc + 6});
        for (int i = 0; i < 7; i++) begin
            if (i == 6) host_req = 1'b0;
            if (i != 5) cpu_exp.push_back(16'hBEEF);
            smp();
            check($sformatf("t5_stall_%0d", i), {31'h0, cpu_stall}, (i == 5) ? 32'h1 : 32'h0);
            nxt();
        end
        cpu_req = 1'b0;

        // 6: reset in the middle of a host write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 16'h0F0F;
        smp();
        nxt();
        cpu_req = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 16'h7777;
        smp();
        nxt();
        smp();
        check("t6_we_before_rst", {31'h0, d_we}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("t6_we_forced_0",   {31'h0, d_we},      32'h0);
        check("t6_ack_in_rst",    {31'h0, host_ack},  32'h0);
        check("t6_rdata_cleared", {16'h0, host_rdata}, 32'h0);
        check("t6_stall_in_rst",  {31'h0, cpu_stall}, 32'h0);
        host_req = 1'b0;
        nxt();
        check("t6_mem_unchanged", {16'h0, mem[8'h30]}, 32'h0F0F);
        #2 reset = 1'b1;
        nxt();
        smp();
        check("t6_ack_after",   {31'h0, host_ack},  32'h0);
        check("t6_stall_after", {31'h0, cpu_stall}, 32'h0);
        nxt();
        // Fresh host read is granted next cycle, so the FSM restarted in S_CPU.
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        host_exp.push_back('{16'hBEEF, cyc + 2});
        smp();
        nxt();
        smp();
        nxt();
        host_req = 1'b0;
        smp();
        nxt();
        nxt();

        check("host_queue_drained", host_exp.size(), 32'h0);
        check("cpu_queue_drained",  cpu_exp.size(),  32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data-memory port (8-bit address, 16-bit data, asynchronous read, synchronous write) between the pipeline MEM stage and a host/debug port used for loading and inspecting data memory.
- Sits between the MEM stage and the data memory.
- The CPU has priority. A bounded-wait counter guarantees the host gets a slot.
- When the host takes the port, the pipeline stalls for one cycle.

Parameters:
MAX_WAIT, 4, cycles a pending host request may lose to the CPU before it is forced through (0 = host always wins)
CNT_W, 3, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT

Ports:
clock  input  1  system clock
reset  input  1  reset, asynchronous, active-low
cpu_req  input  1  MEM stage needs the port this cycle (exec state and LOAD/STORE in MEM)
cpu_we  input  1  CPU store
cpu_addr  input  8  CPU address (low byte of ALU result)
cpu_wdata  input  16  CPU store data
cpu_rdata  output  16  load data to MEM stage, combinational from d_datain
cpu_stall  output  1  pipeline must hold all stage registers this cycle
host_req  input  1  host request, level, held until host_ack
host_we  input  1  host write
host_addr  input  8  host address
host_wdata  input  16  host write data
host_rdata  output  16  registered host read data
host_ack  output  1  one-cycle completion pulse
d_addr  output  8  memory address
d_dataout  output  16  memory write data
d_datain  input  16  memory read data
d_we  output  1  memory write enable

Behaviour:
- FSM states: S_CPU (default), S_HOST, S_ACK. Encodings are 2-bit and live in the shared package.
- S_CPU
  - Memory outputs follow the CPU inputs combinationally.
  - d_we = cpu_req & cpu_we.
  - cpu_stall = 0.
  - Grant host (go to S_HOST) when host_req & (!cpu_req | wait_cnt == MAX_WAIT).
  - Otherwise, if host_req & cpu_req: wait_cnt increments, saturating at MAX_WAIT.
  - If !host_req: wait_cnt = 0.
- S_HOST (exactly 1 cycle)
  - Memory outputs follow the host inputs; d_we = host_we.
  - cpu_stall = cpu_req. The CPU access is not performed and is retried next cycle by the stalled pipeline.
  - On the clock edge: host_rdata <= d_datain (reads only; writes leave host_rdata unchanged); wait_cnt <= 0; go to S_ACK.
- S_ACK (exactly 1 cycle)
  - host_ack = 1.
  - Memory outputs follow the CPU, as in S_CPU.
  - cpu_stall = 0.
  - Next state is S_CPU unconditionally. No host grant is evaluated in S_ACK.
  - The host must drop host_req in the ack cycle. If host_req is still high in the following S_CPU cycle, it is a new request.
- Latency
  - CPU: 0 cycles when not preempted.
  - Host: grant at the earliest in the cycle after host_req is seen; ack 1 cycle after the access.
  - Worst case from host_req to host_ack = MAX_WAIT + 2 cycles.
- Host request withdrawn before grant: no access occurs; wait_cnt clears.
- Simultaneous requests with wait_cnt < MAX_WAIT: CPU wins and cpu_stall = 0.
- Reset low (asynchronous)
  - State -> S_CPU; wait_cnt = 0; host_rdata = 0.
  - d_we is forced 0 combinationally while reset is low, including mid S_HOST write. The host access is then lost and no ack is issued.
- Reset values: host_ack = 0, cpu_stall = 0, host_rdata = 16'h0000, d_we = 0. d_addr and d_dataout follow the CPU inputs.
- cpu_rdata = d_datain at all times; it is only meaningful when cpu_stall = 0.

Decomposition:
- Shared definitions file:
  - state encodings S_CPU = 2'd0, S_HOST = 2'd1, S_ACK = 2'd2;
  - memory address/data width constants (8/16).
- Sub-module dmem_port_mux: a purely combinational 2:1 mux of {addr, wdata, we} selected by the host grant. It keeps the FSM/counter logic in dmem_arbiter separate.

Test Plan:
1. CPU only: cpu_req=1, cpu_we=1, addr 8'h10, wdata 16'hBEEF, host idle -> d_we=1, d_addr=8'h10, cpu_stall=0; a later CPU read of 8'h10 returns 16'hBEEF the same cycle.
2. Host only: host_req=1, host_we=0, addr 8'h10 (holds 16'hBEEF), cpu_req=0 -> S_HOST next cycle, host_ack pulses 1 cycle later, host_rdata=16'hBEEF.
3. Starvation bound: cpu_req=1 continuously and host_req raised, MAX_WAIT=4 -> host is granted in the 5th cycle; cpu_stall=1 in exactly that cycle; host_ack in the 6th; no CPU write occurs during S_HOST.
4. Conflict retry: CPU store 16'h1234 @8'h20 preempted by host write 16'h5555 @8'h20 -> host write first; CPU store retried next cycle; final memory[8'h20]=16'h1234.
5. Withdrawal: host_req high 2 cycles under CPU contention, then low -> no grant, no host_ack, wait_cnt returns to 0.
6. Reset mid-access: assert reset during S_HOST with host_we=1 -> d_we=0 immediately, target location unchanged, after release state S_CPU, host_ack=0, host_rdata=0.
